// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC register, IDLE/FETCH/HALT sequencer and a
// 2-entry {pc, inst} buffer in front of decode, with redirect-driven flushes.
module imem_fetch_ctrl #(
    parameter int unsigned MEM_WORDS = 10,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        halted
);
    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [1:0]  r_count, w_count_next;
    logic        r_rd_ptr, r_wr_ptr;
    logic [31:0] r_fifo_pc   [2];
    logic [31:0] r_fifo_inst [2];
    logic        r_halted;

    logic        w_pop, w_push;
    logic        w_pc_in_range, w_redir_in_range;
    logic [31:0] w_redir_target;

    assign w_redir_target   = redirect_pc & ~32'd3;
    assign w_pc_in_range    = (r_pc < PC_LIMIT);
    assign w_redir_in_range = (w_redir_target < PC_LIMIT);

    assign out_valid = (r_count != 2'd0);
    assign out_inst  = r_fifo_inst[r_rd_ptr];
    assign out_pc    = r_fifo_pc[r_rd_ptr];
    assign Addr      = r_pc;
    assign halted    = r_halted;

    assign w_pop  = out_valid && out_ready;
    assign w_push = (r_state == S_FETCH) && run && w_pc_in_range && !redirect_valid
                    && ((r_count != 2'd2) || w_pop);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_count_next = r_count;
        if (redirect_valid) begin
            // Redirect wins over everything; a pop this cycle is simply absorbed by the flush.
            w_pc_next    = w_redir_target;
            w_count_next = 2'd0;
            if (!w_redir_in_range)
                w_state_next = S_HALT;
            else if (run || (r_state == S_HALT))
                w_state_next = S_FETCH;
            else
                w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (run) w_state_next = S_FETCH;
                S_FETCH: begin
                    if (!w_pc_in_range)
                        w_state_next = S_HALT;
                    else if (!run)
                        w_state_next = S_IDLE;
                end
                S_HALT:  w_state_next = S_HALT;
                default: w_state_next = S_IDLE;
            endcase
            if (w_push)
                w_pc_next = r_pc + 32'd4;
            w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_halted <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_pc[i]   <= 32'd0;
                r_fifo_inst[i] <= 32'd0;
            end
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_count  <= w_count_next;
            r_halted <= (w_state_next == S_HALT);
            if (redirect_valid) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]   <= r_pc;
                    r_fifo_inst[r_wr_ptr] <= Inst;
                    r_wr_ptr              <= ~r_wr_ptr;
                end
                if (w_pop)
                    r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_imem_fetch_ctrl;
    localparam int          MEM_WORDS = 10;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] LIMIT     = 32'(MEM_WORDS * 4);
    localparam int          M_IDLE = 0, M_FETCH = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] Addr, Inst, out_inst, out_pc;
    logic        out_valid, halted;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc;
    int          m_mode;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if ((a >> 2) < MEM_WORDS) return 32'h1000 + (a >> 2);
        return 32'hBAD0_0000 ^ a;
    endfunction

    assign Inst = mem_word(Addr);

    imem_fetch_ctrl #(.MEM_WORDS(MEM_WORDS), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .Addr(Addr), .Inst(Inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc   = RESET_PC;
        m_mode = M_IDLE;
    endtask

    // One clock of behaviour, evaluated from the inputs present at the edge.
    task automatic model_step();
        logic [31:0] tgt;
        ent_t        e;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (redirect_valid) begin
            q.delete();
            tgt  = redirect_pc & ~32'd3;
            m_pc = tgt;
            if (tgt >= LIMIT) m_mode = M_HALT;
            else if (run || m_mode == M_HALT) m_mode = M_FETCH;
            else m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (run) m_mode = M_FETCH;
        end else if (m_mode == M_FETCH) begin
            if (m_pc >= LIMIT) m_mode = M_HALT;
            else if (!run) m_mode = M_IDLE;
            else if (q.size() < 2) begin
                e.pc   = m_pc;
                e.inst = mem_word(m_pc);
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        chk("addr", Addr, m_pc);
        chk("out_valid", {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        chk("halted", {31'd0, halted}, (m_mode == M_HALT) ? 32'd1 : 32'd0);
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_inst", out_inst, q[0].inst);
        end
        $display("t=%0t run=%b rdy=%b redir=%b rpc=%h | addr=%h v=%b pc=%h inst=%h halt=%b",
                 $time, run, out_ready, redirect_valid, redirect_pc, Addr, out_valid,
                 out_pc, out_inst, halted);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr", Addr, RESET_PC);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        #10;
        rst_n = 1'b1; run = 1'b1; out_ready = 1'b1;

        // Streaming start: IDLE->FETCH, then first push, visible a cycle later.
        cycle();
        chk("first_not_yet", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("first_pc", out_pc, 32'd0);
        chk("first_inst", out_inst, 32'h1000);
        cycle();
        chk("second_pc", out_pc, 32'd4);

        // Backpressure: buffer fills, PC and head freeze.
        out_ready = 1'b0;
        repeat (5) cycle();
        chk("bp_head_pc", out_pc, 32'd4);
        chk("bp_pc_hold", Addr, 32'd12);
        out_ready = 1'b1;

        // Run off the end of memory into HALT and drain.
        repeat (12) cycle();
        chk("end_halted", {31'd0, halted}, 32'd1);
        chk("end_addr", Addr, LIMIT);
        chk("end_drained", {31'd0, out_valid}, 32'd0);

        // Out-of-range redirect keeps HALT; in-range one resumes.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("halt_oor_halted", {31'd0, halted}, 32'd1);
        chk("halt_oor_novalid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'd8;
        cycle();
        redirect_valid = 1'b0;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        wait_valid("resume_timeout", 5);
        chk("resume_pc", out_pc, 32'd8);

        // Redirect with a full buffer and a simultaneous pop.
        out_ready = 1'b0;
        repeat (3) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_000E; out_ready = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        wait_valid("flush_timeout", 5);
        chk("flush_pc", out_pc, 32'd12);
        chk("flush_inst", out_inst, 32'h1003);

        // Short asynchronous reset pulse with a full buffer.
        out_ready = 1'b0;
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_addr", Addr, RESET_PC);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        wait_valid("restart_timeout", 5);
        chk("restart_pc", out_pc, RESET_PC);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int r;
            run       = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = (m_mode == M_HALT) ? ($urandom_range(0, 2) == 0)
                                                : ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 9);
            if (r < 7)      redirect_pc = $urandom_range(0, LIMIT - 1);
            else if (r < 9) redirect_pc = $urandom_range(LIMIT, LIMIT + 16);
            else            redirect_pc = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
